// File: rtl/uart_pkg.sv
// Shared encodings for the UART transmit arbiter: FSM states and baud codes.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_ISSUE     = 2'b01,
        ST_WAIT_BUSY = 2'b10,
        ST_WAIT_DONE = 2'b11
    } arb_state_t;

    localparam logic [2:0] BAUD_1200   = 3'b000;
    localparam logic [2:0] BAUD_2400   = 3'b001;
    localparam logic [2:0] BAUD_4800   = 3'b010;
    localparam logic [2:0] BAUD_9600   = 3'b011;
    localparam logic [2:0] BAUD_19200  = 3'b100;
    localparam logic [2:0] BAUD_38400  = 3'b101;
    localparam logic [2:0] BAUD_57600  = 3'b110;
    localparam logic [2:0] BAUD_115200 = 3'b111;

    localparam logic [2:0] DEFAULT_BAUD = BAUD_115200;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request after ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx
);

    always_comb begin
        int  cand;
        logic found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        // Offset 1 first so the last winner is searched last.
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[IDX_W'(cand)]) begin
                found             = 1'b1;
                gnt[IDX_W'(cand)] = 1'b1;
                idx               = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte producers,
// sequencing the Tx_WR / Tx_BUSY handshake one byte per grant.
module uart_tx_arbiter #(
    parameter int          NUM_REQ      = 4,
    parameter int          BUSY_TIMEOUT = 16,
    parameter logic [2:0]  DEFAULT_BAUD = uart_pkg::DEFAULT_BAUD
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [2:0]           baud_cfg,
    input  logic                 err_clr,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   gnt_ack,
    output logic [7:0]           Tx_DATA,
    output logic                 Tx_WR,
    output logic                 Tx_EN,
    output logic [2:0]           baud_select,
    input  logic                 Tx_BUSY,
    output logic                 arb_busy,
    output logic                 timeout_err
);

    import uart_pkg::*;

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

    arb_state_t           state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 tx_wr_q, tx_wr_d;
    logic                 tx_en_q, tx_en_d;
    logic [NUM_REQ-1:0]   gnt_ack_q, gnt_ack_d;
    logic [2:0]           baud_q, baud_d;
    logic                 arb_busy_q, arb_busy_d;
    logic                 timeout_q, timeout_d;

    logic [NUM_REQ-1:0]   win_gnt;
    logic [IDX_W-1:0]     win_idx;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req (req),
        .ptr (ptr_q),
        .gnt (win_gnt),
        .idx (win_idx)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        tx_data_d = tx_data_q;
        tx_wr_d   = 1'b0;
        tx_en_d   = tx_en_q;
        gnt_ack_d = '0;
        baud_d    = baud_q;
        timeout_d = timeout_q;

        // Clear first so a timeout detected in the same cycle still sets the flag.
        if (err_clr) begin
            timeout_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (enable && (|req) && !Tx_BUSY) begin
                    tx_data_d = req_data[{win_idx, 3'b000} +: 8];
                    baud_d    = baud_cfg;
                    tx_wr_d   = 1'b1;
                    tx_en_d   = 1'b1;
                    gnt_ack_d = win_gnt;
                    ptr_d     = win_idx;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (Tx_BUSY) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    tx_en_d   = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                // Frame length scales with baud rate, so no timeout here.
                if (!Tx_BUSY) begin
                    tx_en_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        arb_busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            tx_data_q  <= '0;
            tx_wr_q    <= 1'b0;
            tx_en_q    <= 1'b0;
            gnt_ack_q  <= '0;
            baud_q     <= DEFAULT_BAUD;
            arb_busy_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            tx_data_q  <= tx_data_d;
            tx_wr_q    <= tx_wr_d;
            tx_en_q    <= tx_en_d;
            gnt_ack_q  <= gnt_ack_d;
            baud_q     <= baud_d;
            arb_busy_q <= arb_busy_d;
            timeout_q  <= timeout_d;
        end
    end

    assign gnt_ack     = gnt_ack_q;
    assign Tx_DATA     = tx_data_q;
    assign Tx_WR       = tx_wr_q;
    assign Tx_EN       = tx_en_q;
    assign baud_select = baud_q;
    assign arb_busy    = arb_busy_q;
    assign timeout_err = timeout_q;

endmodule
